code_lock_ctrl: RTL and testbench

Password-entry controller for the code lock. It consumes the single-cycle key pulses produced by the key debouncer: bit0 increments the current digit, bit1 commits it. It assembles a DIGITS-long BCD code, compares it against a parameter code, and drives the unlock, error and alarm indications. It sits directly downstream of the debouncer and upstream of the LED and segment display logic.

---
 rtl/code_lock_ctrl.sv | 120 ++++++++++++
 tb/tb_code_lock_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Password-entry controller: assembles a BCD code from debounced key pulses,
// compares it against CODE and drives the unlock / error / alarm indications.
module code_lock_ctrl #(
    parameter int unsigned          DIGITS       = 4,
    parameter logic [4*DIGITS-1:0]  CODE         = 16'h1234,
    parameter int unsigned          MAX_TRY      = 3,
    parameter int unsigned          OPEN_CYCLES  = 12_000_000,
    parameter int unsigned          ALARM_CYCLES = 36_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_pulse,
    output logic [3:0] cur_digit,
    output logic [2:0] digit_idx,
    output logic       unlock,
    output logic       err_pulse,
    output logic       alarm,
    output logic [3:0] err_cnt
);

    localparam int unsigned TMAX = (OPEN_CYCLES > ALARM_CYCLES) ? OPEN_CYCLES : ALARM_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0]    LAST_IDX   = 3'(DIGITS - 1);
    localparam logic [3:0]    MAX_TRY_L  = 4'(MAX_TRY);
    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ENTRY = 2'd0,
        S_CHECK = 2'd1,
        S_OPEN  = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [4*DIGITS-1:0] entered, entered_n;
    logic [TW-1:0]       timer, timer_n;
    logic [3:0]          cur_n, err_cnt_n;
    logic [2:0]          idx_n;
    logic                err_pulse_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ENTRY;
            entered   <= '0;
            timer     <= '0;
            cur_digit <= '0;
            digit_idx <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            entered   <= entered_n;
            timer     <= timer_n;
            cur_digit <= cur_n;
            digit_idx <= idx_n;
            err_cnt   <= err_cnt_n;
            err_pulse <= err_pulse_n;
            // Indications follow the state being entered so they stay registered
            unlock    <= (state_n == S_OPEN);
            alarm     <= (state_n == S_ALARM);
        end
    end

    // Timer defaults to zero, so every state transition restarts it
    always_comb begin
        state_n     = state;
        entered_n   = entered;
        timer_n     = '0;
        cur_n       = cur_digit;
        idx_n       = digit_idx;
        err_cnt_n   = err_cnt;
        err_pulse_n = 1'b0;

        case (state)
            S_ENTRY: begin
                if (key_pulse[1]) begin
                    entered_n = {entered[4*DIGITS-5:0], cur_digit};
                    cur_n     = '0;
                    if (digit_idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = S_CHECK;
                    end else begin
                        idx_n = digit_idx + 3'd1;
                    end
                end else if (key_pulse[0]) begin
                    cur_n = (cur_digit == 4'd9) ? '0 : cur_digit + 4'd1;
                end
            end
            S_CHECK: begin
                entered_n = '0;
                if (entered == CODE) begin
                    err_cnt_n = '0;
                    state_n   = S_OPEN;
                end else begin
                    err_cnt_n   = err_cnt + 4'd1;
                    err_pulse_n = 1'b1;
                    state_n     = (err_cnt + 4'd1 == MAX_TRY_L) ? S_ALARM : S_ENTRY;
                end
            end
            S_OPEN: begin
                if (key_pulse[1] || timer == OPEN_LAST) state_n = S_ENTRY;
                else                                    timer_n = timer + TW'(1);
            end
            S_ALARM: begin
                if (timer == ALARM_LAST) begin
                    state_n   = S_ENTRY;
                    err_cnt_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_ENTRY;
        endcase
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: scoreboard of expected unlock/error
// events plus direct checks of digit entry, hold times and reset.
module tb_code_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_pulse;
    logic [3:0] cur_digit;
    logic [2:0] digit_idx;
    logic       unlock, err_pulse, alarm;
    logic [3:0] err_cnt;

    code_lock_ctrl #(
        .DIGITS(4), .CODE(16'h1234), .MAX_TRY(3), .OPEN_CYCLES(8), .ALARM_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .cur_digit(cur_digit),
        .digit_idx(digit_idx), .unlock(unlock), .err_pulse(err_pulse),
        .alarm(alarm), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_unlock;
        int unsigned cnt;
        int unsigned due;
    } ev_t;

    ev_t         sb[$];
    int unsigned cyc = 0;
    int unsigned n_tests = 0, n_fail = 0;
    int unsigned unl_run = 0, unl_len = 0, alm_run = 0, alm_len = 0;
    bit          unl_prev = 0, err_prev = 0, alm_prev = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Event monitor: pops the scoreboard on each unlock rise or error pulse
    always @(negedge clk) begin
        if (!rst) begin
            unl_prev = 0; err_prev = 0; alm_prev = 0;
            unl_run = 0; alm_run = 0;
        end else begin
            if (err_prev) check("err_single", err_pulse, 0);
            if ((unlock && !unl_prev) || (err_pulse && !err_prev)) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", {unlock, err_pulse}, 0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    check("ev_kind", unlock, e.is_unlock);
                    check("ev_errcnt", err_cnt, e.cnt);
                    check("ev_cycle", cyc, e.due);
                end
            end
            if (unlock) unl_run++;
            else if (unl_prev) begin unl_len = unl_run; unl_run = 0; end
            if (alarm) alm_run++;
            else if (alm_prev) begin alm_len = alm_run; alm_run = 0; end
            unl_prev = unlock; err_prev = err_pulse; alm_prev = alarm;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [1:0] k);
        key_pulse = k;
        tick();
        key_pulse = 2'b00;
    endtask

    // Enters a 4-digit code; the final commit queues the expected outcome
    task automatic enter_code(input logic [15:0] code, input bit ok, input int unsigned cnt);
        for (int i = 0; i < 4; i++) begin
            int unsigned d;
            d = code[15-4*i -: 4];
            repeat (d) press(2'b01);
            check("entry_digit", cur_digit, d);
            check("entry_idx", digit_idx, i);
            if (i == 3) sb.push_back('{ok, cnt, cyc + 2});
            press(2'b10);
        end
        tick();
    endtask

    task automatic wait_sig(input bit use_alarm, input bit lvl, input int unsigned bound,
                            input string tag);
        int unsigned n = 0;
        while (((use_alarm ? alarm : unlock) != lvl) && n < bound) begin
            tick();
            n++;
        end
        if ((use_alarm ? alarm : unlock) != lvl) check(tag, use_alarm ? alarm : unlock, lvl);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        key_pulse = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cur", cur_digit, 0);
        check("rst_idx", digit_idx, 0);
        check("rst_unlock", unlock, 0);
        check("rst_alarm", alarm, 0);
        check("rst_err", err_pulse, 0);
        check("rst_errcnt", err_cnt, 0);
        rst = 1'b1;
        tick();

        // Correct code, unlock held for the full open time
        enter_code(16'h1234, 1, 0);
        check("open_errcnt", err_cnt, 0);
        wait_sig(0, 1, 10, "open_rise_timeout");
        wait_sig(0, 0, 20, "open_fall_timeout");
        check("open_len", unl_len, 8);
        check("open_idx", digit_idx, 0);

        // Digit wrap
        repeat (10) press(2'b01);
        check("wrap10", cur_digit, 0);
        press(2'b01);
        check("wrap11", cur_digit, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Three wrong attempts reach the alarm; keys ignored while it is up
        enter_code(16'h1235, 0, 1);
        tick();
        enter_code(16'h1235, 0, 2);
        tick();
        enter_code(16'h1235, 0, 3);
        repeat (3) press(2'b01);
        press(2'b10);
        press(2'b11);
        check("alarm_hi", alarm, 1);
        check("alarm_cur", cur_digit, 0);
        check("alarm_idx", digit_idx, 0);
        check("alarm_cnt", err_cnt, 3);
        wait_sig(1, 0, 30, "alarm_fall_timeout");
        check("alarm_len", alm_len, 16);
        check("post_alarm_cnt", err_cnt, 0);
        check("post_alarm_unlock", unlock, 0);

        // Two failures, then the correct code clears the count; relock by enter
        enter_code(16'h9999, 0, 1);
        tick();
        enter_code(16'h0000, 0, 2);
        tick();
        enter_code(16'h1234, 1, 0);
        check("retry_cnt", err_cnt, 0);
        tick();
        press(2'b01);
        check("open_inc_ignored", unlock, 1);
        press(2'b10);
        check("relock", unlock, 0);
        check("relock_cur", cur_digit, 0);
        tick();

        // Simultaneous pulses commit without incrementing
        press(2'b01);
        press(2'b11);
        check("both_cur", cur_digit, 0);
        check("both_idx", digit_idx, 1);
        for (int i = 1; i < 4; i++) begin
            repeat (i + 1) press(2'b01);
            if (i == 3) sb.push_back('{1'b1, 0, cyc + 2});
            press(2'b10);
        end
        wait_sig(0, 1, 10, "both_rise_timeout");
        wait_sig(0, 0, 20, "both_fall_timeout");
        check("both_len", unl_len, 8);

        // Asynchronous reset mid-entry discards the partial code
        press(2'b01);
        press(2'b10);
        repeat (2) press(2'b01);
        press(2'b10);
        press(2'b01);
        #2 rst = 1'b0;
        #1;
        check("async_idx", digit_idx, 0);
        check("async_cur", cur_digit, 0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        enter_code(16'h1234, 1, 0);
        wait_sig(0, 1, 10, "final_rise_timeout");
        wait_sig(0, 0, 20, "final_fall_timeout");
        check("final_len", unl_len, 8);

        repeat (5) tick();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
